fpu_addsub_pipe: RTL

FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

---
 rtl/fpu_addsub_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: 3-stage IEEE-style floating-point adder/subtractor with a global stall.
// Ports: i_clk/i_rst_n (rising clock, async active-low reset).
//   i_valid/o_ready: operand handshake.
//   i_add_sub: 0 = a+b, 1 = a-b.
//   i_32_a/i_32_b: operands.
//   o_valid/i_ready: result handshake.
//   o_32_s: result.
//   o_ov_flag/o_un_flag: per-result flags, qualified by o_valid.
//   i_flag_clr: clears the sticky flags.
//   o_sticky_ov/o_sticky_un: sticky flags, present only with FPU_STICKY_FLAGS_EN.
// Rounding is round-to-nearest-even. Subnormal inputs are flushed to zero.
module fpu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_add_sub,
  input  logic [EXP_W+MAN_W:0] i_32_a,
  input  logic [EXP_W+MAN_W:0] i_32_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [EXP_W+MAN_W:0] o_32_s,
  output logic                 o_ov_flag,
  output logic                 o_un_flag,
  input  logic                 i_flag_clr,
  output logic                 o_sticky_ov,
  output logic                 o_sticky_un
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;
  localparam int N = MAN_W + 5;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] M_E = EXP_W'(M);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic adv;
  assign adv = !o_valid || i_ready;
  assign o_ready = adv;
  logic sa, sb, nan_a, nan_b, inf_a, inf_b, swap, bad, spec;
  logic [EXP_W-1:0] ea, eb, e_big, d, ds;
  logic [MAN_W-1:0] fa, fb;
  logic [M-1:0] m_big, m_small, small_al;
  logic [2*M-1:0] wide;
  logic [W-1:0] spec_val;
  assign sa = i_32_a[W-1];
  assign sb = i_32_b[W-1] ^ i_add_sub;
  assign ea = i_32_a[W-2:MAN_W];
  assign eb = i_32_b[W-2:MAN_W];
  assign fa = ea == '0 ? '0 : i_32_a[MAN_W-1:0];
  assign fb = eb == '0 ? '0 : i_32_b[MAN_W-1:0];
  assign nan_a = ea == EMAX && fa != '0;
  assign nan_b = eb == EMAX && fb != '0;
  assign inf_a = ea == EMAX && fa == '0;
  assign inf_b = eb == EMAX && fb == '0;
  assign swap = {eb, fb} > {ea, fa};
  assign e_big = swap ? eb : ea;
  assign m_big = swap ? {eb != '0, fb, 3'b000} : {ea != '0, fa, 3'b000};
  assign m_small = swap ? {ea != '0, fa, 3'b000} : {eb != '0, fb, 3'b000};
  assign d = swap ? eb - ea : ea - eb;
  // Shifts past the mantissa width collapse entirely into the sticky bit.
  assign ds = d > M_E ? M_E : d;
  assign wide = {m_small, {M{1'b0}}} >> ds;
  assign small_al = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};
  assign bad = nan_a || nan_b || (inf_a && inf_b && (sa ^ sb));
  assign spec = nan_a || nan_b || inf_a || inf_b;
  assign spec_val = bad ? QNAN : {inf_a ? sa : sb, EMAX, {MAN_W{1'b0}}};
  logic v1, sp1, sg1, sub1;
  logic [W-1:0] sv1;
  logic [EXP_W-1:0] e1;
  logic [M-1:0] mb1, ms1;
  logic v2, sp2, sg2, sub2;
  logic [W-1:0] sv2;
  logic [EXP_W-1:0] e2;
  logic [N-1:0] sum2;
  logic [EXP_W+1:0] lz, e_n, e_r;
  logic [N-1:0] shl;
  logic [M-1:0] m_n;
  logic [MAN_W+1:0] mr;
  logic up, zero, uf, ov;
  logic [W-1:0] res;
  always_comb begin
    lz = '0;
    for (int i = 0; i < N - 1; i++) lz = sum2[i] ? (EXP_W+2)'(N - 2 - i) : lz;
  end
  assign shl = sum2 << lz;
  // A carry out shifts right by one; otherwise shift left to bring the leading one up.
  assign m_n = sum2[N-1] ? {sum2[N-1:2], |sum2[1:0]} : shl[M-1:0];
  assign e_n = sum2[N-1] ? {2'b00, e2} + {{(EXP_W+1){1'b0}}, 1'b1} : {2'b00, e2} - lz;
  assign up = m_n[2] && (m_n[1] || m_n[0] || m_n[3]);
  assign mr = {1'b0, m_n[M-1:3]} + {{(MAN_W+1){1'b0}}, up};
  assign e_r = e_n + {{(EXP_W+1){1'b0}}, mr[MAN_W+1]};
  assign zero = sum2 == '0;
  assign uf = !zero && (e_n[EXP_W+1] || e_n == '0);
  assign ov = !zero && !uf && e_r >= {2'b00, EMAX};
  assign res = sp2 ? sv2 :
               zero ? {!sub2 && sg2, {(W-1){1'b0}}} :
               uf ? {sg2, {(W-1){1'b0}}} :
               ov ? {sg2, EMAX, {MAN_W{1'b0}}} :
               {sg2, e_r[EXP_W-1:0], mr[MAN_W-1:0]};
  logic unused_bits;
  assign unused_bits = ^{mr[MAN_W], shl[N-1]};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {v1, sp1, sg1, sub1, sv1, e1, mb1, ms1} <= '0;
      {v2, sp2, sg2, sub2, sv2, e2, sum2} <= '0;
      {o_valid, o_32_s, o_ov_flag, o_un_flag} <= '0;
    end else if (adv) begin
      v1 <= i_valid;
      sp1 <= spec;
      sv1 <= spec_val;
      sg1 <= swap ? sb : sa;
      sub1 <= sa ^ sb;
      e1 <= e_big;
      mb1 <= m_big;
      ms1 <= small_al;
      v2 <= v1;
      sp2 <= sp1;
      sv2 <= sv1;
      sg2 <= sg1;
      sub2 <= sub1;
      e2 <= e1;
      sum2 <= sub1 ? {1'b0, mb1} - {1'b0, ms1} : {1'b0, mb1} + {1'b0, ms1};
      o_valid <= v2;
      o_32_s <= res;
      o_ov_flag <= !sp2 && ov;
      o_un_flag <= !sp2 && uf;
    end
  end
`ifdef FPU_STICKY_FLAGS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sticky_ov <= 1'b0;
      o_sticky_un <= 1'b0;
    end else begin
      o_sticky_ov <= (o_valid && i_ready && o_ov_flag) || (o_sticky_ov && !i_flag_clr);
      o_sticky_un <= (o_valid && i_ready && o_un_flag) || (o_sticky_un && !i_flag_clr);
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = i_flag_clr;
  assign o_sticky_ov = 1'b0;
  assign o_sticky_un = 1'b0;
`endif
endmodule
